// File: rtl/square_root_module.sv
// Multi-cycle significand square-root / inverse-square-root unit for the lampFPU.
// Bit-serial restoring sqrt (W cycles) optionally followed by restoring division 2^(2W-2)/root (W+1 cycles).
module square_root_module #(
  parameter int F_DW = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    doSqrt_i,
  input  logic [F_DW:0]           s_i,
  input  logic                    is_exp_odd_i,
  input  logic                    invSqrt_i,
  input  logic                    special_case_i,
  output logic [2*(F_DW+1)-1:0]   res_o,
  output logic                    valid_o,
  output logic [2:0]              dbg_state_o
);

  localparam int W       = 2 * (F_DW + 1);
  localparam int RW      = 2 * W;
  localparam int RMW     = W + 2;
  localparam int CW      = $clog2(W + 1);
  localparam int SH_EVEN = RW - 2 - F_DW;
  localparam int SH_ODD  = RW - 1 - F_DW;

  localparam logic [CW-1:0]  SQRT_LAST    = CW'(W - 1);
  localparam logic [CW-1:0]  DIV_LAST     = CW'(W);
  // Dividend 2^(2W-2) pre-shifted by the W+1 quotient bits still to be produced.
  localparam logic [RMW-1:0] DIV_REM_INIT = RMW'(1) << (W - 3);
  // A divisor at or below this value yields a quotient of at least 2^(W+1).
  localparam logic [W-1:0]   DIV_SAT_LIM  = W'(1) << (W - 3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SPEC = 3'd1,
    S_SQRT = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [RW-1:0]    rad_q,   rad_d;
  logic [RMW-1:0]   rem_q,   rem_d;
  logic [W-1:0]     root_q,  root_d;
  logic [W:0]       quo_q,   quo_d;
  logic             inv_q,   inv_d;
  logic             spec_q,  spec_d;
  logic [W-1:0]     res_q,   res_d;
  logic             valid_q, valid_d;

  logic [RMW-1:0]   sq_sh;
  logic [RMW-1:0]   sq_trial;
  logic             sq_ge;
  logic [RMW-1:0]   dv_sh;
  logic [RMW-1:0]   dv_div;
  logic             dv_ge;
  logic             sat;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    quo_d    = quo_q;
    inv_d    = inv_q;
    spec_d   = spec_q;
    res_d    = res_q;
    valid_d  = 1'b0;

    // Remainder never exceeds 2*root before the shift, so the dropped top bits are always zero.
    sq_sh    = RMW'({rem_q, rad_q[RW-1:RW-2]});
    sq_trial = {root_q, 2'b01};
    sq_ge    = (sq_sh >= sq_trial);

    dv_sh    = RMW'({rem_q, 1'b0});
    dv_div   = {2'b00, root_q};
    dv_ge    = (dv_sh >= dv_div);

    sat      = (root_q <= DIV_SAT_LIM) | quo_q[W];

    case (state_q)
      S_IDLE: begin
        if (doSqrt_i) begin
          inv_d  = invSqrt_i;
          spec_d = special_case_i;
          rad_d  = is_exp_odd_i ? ({{(RW-F_DW-1){1'b0}}, s_i} << SH_ODD)
                                : ({{(RW-F_DW-1){1'b0}}, s_i} << SH_EVEN);
          rem_d  = '0;
          root_d = '0;
          quo_d  = '0;
          cnt_d  = '0;
          state_d = special_case_i ? S_SPEC : S_SQRT;
        end
      end

      S_SPEC: begin
        state_d = S_DONE;
      end

      S_SQRT: begin
        rem_d  = sq_ge ? (sq_sh - sq_trial) : sq_sh;
        root_d = {root_q[W-2:0], sq_ge};
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == SQRT_LAST) begin
          cnt_d = '0;
          if (inv_q) begin
            state_d = S_DIV;
            rem_d   = DIV_REM_INIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DIV: begin
        rem_d = dv_ge ? (dv_sh - dv_div) : dv_sh;
        quo_d = {quo_q[W-1:0], dv_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        if (spec_q) begin
          res_d = '0;
        end else if (inv_q) begin
          res_d = sat ? '1 : quo_q[W-1:0];
        end else begin
          res_d = root_q;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      quo_q   <= '0;
      inv_q   <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      quo_q   <= quo_d;
      inv_q   <= inv_d;
      spec_q  <= spec_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign res_o       = res_q;
  assign valid_o     = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_square_root_module.sv
// Self-checking bench for square_root_module: directed spec points, randomized ops against an
// arithmetic reference model, reset abort and back-to-back operation.
module tb_square_root_module;

  localparam int F_DW = 7;
  localparam int W    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            doSqrt_i;
  logic [F_DW:0]   s_i;
  logic            is_exp_odd_i;
  logic            invSqrt_i;
  logic            special_case_i;
  logic [W-1:0]    res_o;
  logic            valid_o;
  logic [2:0]      dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  square_root_module #(.F_DW(F_DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .doSqrt_i       (doSqrt_i),
    .s_i            (s_i),
    .is_exp_odd_i   (is_exp_odd_i),
    .invSqrt_i      (invSqrt_i),
    .special_case_i (special_case_i),
    .res_o          (res_o),
    .valid_o        (valid_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_result(input logic [F_DW:0] s, input bit odd,
                                              input bit inv, input bit sp);
    longint r_int;
    longint root;
    longint q;
    if (sp) return '0;
    r_int = longint'(s) * (odd ? 64'd16777216 : 64'd8388608);
    root  = longint'($sqrt(real'(r_int)));
    while (root * root > r_int) root--;
    while ((root + 1) * (root + 1) <= r_int) root++;
    if (!inv) return root[W-1:0];
    if (root == 0) return '1;
    q = 64'd1073741824 / root;
    if (q >= 65536) return '1;
    return q[W-1:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic run_op(input logic [F_DW:0] s, input bit odd, input bit inv, input bit sp,
                        input bit use_model, input logic [W-1:0] exp_dir, input string tag);
    logic [W-1:0] exp_res;
    int lat;
    int exp_lat;
    bit seen;
    exp_res = use_model ? ref_result(s, odd, inv, sp) : exp_dir;
    exp_q.push_back(exp_res);
    exp_lat = sp ? 2 : (inv ? 34 : 17);

    @(negedge clk);
    s_i            = s;
    is_exp_odd_i   = odd;
    invSqrt_i      = inv;
    special_case_i = sp;
    doSqrt_i       = 1'b1;
    @(posedge clk);

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      if (valid_o) begin
        seen = 1'b1;
      end else begin
        s_i            = F_DW'($urandom_range(0, 255));
        is_exp_odd_i   = 1'($urandom_range(0, 1));
        invSqrt_i      = 1'($urandom_range(0, 1));
        special_case_i = 1'($urandom_range(0, 1));
        doSqrt_i       = (!sp && lat < 4) ? 1'b1 : 1'b0;
        @(posedge clk);
        lat++;
      end
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_res"}, res_o, exp_q.pop_front());
    doSqrt_i = 1'b0;
    @(negedge clk);
    check_eq({tag, "_pulse_width"}, valid_o, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pulses;
    int pulse_q[$];
    logic [F_DW:0] s_b2b;
    logic [W-1:0]  exp_b2b;

    rst            = 1'b0;
    doSqrt_i       = 1'b0;
    s_i            = '0;
    is_exp_odd_i   = 1'b0;
    invSqrt_i      = 1'b0;
    special_case_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_res", res_o, 16'h0000);
    check_eq("reset_valid", valid_o, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_valid", valid_o, 1'b0);

    run_op(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, "sqrt_one");
    run_op(8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 16'hB504, "sqrt_two");
    run_op(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5A82, "inv_two");
    run_op(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'hB4AA, "sqrt_max");
    run_op(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0B50, "sqrt_min");
    run_op(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, "inv_sat_small");
    run_op(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, "inv_sat_zero");
    run_op(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "special");
    run_op(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, "inv_max_odd");
    run_op(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "refill");

    for (int i = 0; i < 30; i++) begin
      run_op(F_DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), 1'b1, 16'h0000, "rand");
    end

    // Reset in the middle of a sqrt must abort silently and clear the result.
    @(negedge clk);
    s_i            = 8'hB7;
    is_exp_odd_i   = 1'b1;
    invSqrt_i      = 1'b0;
    special_case_i = 1'b0;
    doSqrt_i       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    doSqrt_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_res", res_o, 16'h0000);
    check_eq("abort_valid", valid_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check_eq("abort_no_pulse", pulses, 0);
    check_eq("abort_res_held", res_o, 16'h0000);
    run_op(8'hB7, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "after_abort");

    // doSqrt_i held high: the second op must start in the cycle after the first pulse.
    s_b2b   = F_DW'($urandom_range(128, 255));
    exp_b2b = ref_result(s_b2b, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    s_i            = s_b2b;
    is_exp_odd_i   = 1'b0;
    invSqrt_i      = 1'b0;
    special_case_i = 1'b0;
    doSqrt_i       = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_o) begin
        pulse_q.push_back(c);
        check_eq("b2b_res", res_o, exp_b2b);
      end
      if (c == 35) doSqrt_i = 1'b0;
    end
    check_eq("b2b_count", pulse_q.size(), 2);
    if (pulse_q.size() >= 2) begin
      check_eq("b2b_first", pulse_q[0], 17);
      check_eq("b2b_second", pulse_q[1], 35);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
